snake_body: RTL and testbench
=============================

Name: snake_body

Overview:
- Owns the snake's segment list as a circular buffer of tile coordinates.
- Applies moves and growth on each game tick, and detects wall and self collisions.
- Continuously streams every segment, head first, one per clock, to the display stage on snake_x/snake_y/snake_first/snake_last/snake_valid.
- Sits between the game-tick/input logic and the VGA renderer.

Parameters:
- GAME_WIDTH, 20, playfield columns; legal x is 1..GAME_WIDTH.
- GAME_HEIGHT, 15, playfield rows; legal y is 1..GAME_HEIGHT.
- MAX_LEN, 32, buffer depth (power of two) and the winning length.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- step  in  1  one-cycle pulse: advance the snake one tile.
- dir  in  2  requested direction: 00 right, 01 down, 10 left, 11 up.
- grow  in  1  sampled with step: keep the tail, so length increases by 1.
- head_x  out  5  current head column.
- head_y  out  4  current head row.
- snake_x  out  5  streamed segment column.
- snake_y  out  4  streamed segment row.
- snake_first  out  1  streamed segment is the head (index 0).
- snake_last  out  1  streamed segment is the tail (index length-1).
- snake_valid  out  1  stream outputs are meaningful.
- length  out  6  segment count, range 3..MAX_LEN.
- failure  out  1  sticky: wall or self collision.
- success  out  1  sticky: length reached MAX_LEN.

Behaviour:

FSM: INIT, RUN, OVER.

INIT:
- Entered on rst.
- Takes 3 cycles, writing (3,8), (2,8), (1,8) into slots 2, 1, 0. Head pointer is 2.
- Sets length=3, last_dir=00, failure=0, success=0.
- Then moves to RUN.
- Reset values: head=(3,8), length=3. All stream outputs, failure and success are 0 throughout INIT.

RUN, on step:
- eff_dir = dir, unless dir is the exact opposite of last_dir; then eff_dir = last_dir.
- new_head = head ± 1 on the axis of eff_dir. Unsigned arithmetic, no saturation: x=0 and x=GAME_WIDTH+1 are representable.
- Wall collision: new x ∈ {0, GAME_WIDTH+1} or new y ∈ {0, GAME_HEIGHT+1}.
  - Set failure and go to OVER.
  - The buffer is NOT updated, so the displayed snake stays on the field.
- Otherwise:
  - Write new_head to slot (head_ptr+1) mod MAX_LEN and advance head_ptr.
  - head_x/head_y update on the following cycle edge (1-cycle latency).
  - last_dir <= eff_dir.
  - If grow, length increments.
  - If the new length == MAX_LEN, set success and go to OVER.
- step during INIT or OVER is ignored.
- step and rst in the same cycle: rst wins.

OVER:
- Frozen: no moves, no growth.
- Streaming continues.
- Leaves only via rst.

Stream:
- Runs free in RUN and OVER.
- At each pass start it snapshots (head_ptr, length).
- Index i = 0..len-1 reads slot (snap_ptr - i) mod MAX_LEN.
- Outputs are registered: 1-cycle latency from index to output.
- snake_first is asserted at i=0; snake_last at i=len-1.
- The next pass starts on the cycle immediately after snake_last; there are no gap cycles.
- snake_valid=1 on every cycle of a pass.
- A step during a pass does not alter that pass. It cannot corrupt the pass, because the write slot lies outside the snapshot while len < MAX_LEN.

Self collision:
- Each streamed segment with i≥1 is compared to the live head register.
- A match sets failure and moves RUN→OVER.
- Detection latency ≤ MAX_LEN+2 cycles after the head update.
- Moving into the cell the tail vacates in the same step is legal: the tail is no longer in the new snapshot.

length output is 3 at reset and never exceeds MAX_LEN.

Decomposition:
- The shared common.sv package holds:
  - GAME_WIDTH/GAME_HEIGHT;
  - the coordinate widths (5-bit x, 4-bit y);
  - the direction enum (DIR_RIGHT/DOWN/LEFT/UP);
  - the start position constants.
- One sub-module, snake_streamer: the snapshot, the index counter, the read address and the registered first/last/valid.
- The parent keeps the FSM, the buffer, the move/grow logic and collision detection.

Test Plan:
- Reset, then run 10 cycles → stream repeats (3,8)F, (2,8), (1,8)L; length=3; failure=0.
- step with dir=00 and grow=0, twice → head=(5,8); next full pass streams (5,8), (4,8), (3,8); length=3.
- step with dir=10 (reverse) straight after reset → treated as 00; head=(4,8); no failure.
- step with grow=1 → length=4; next pass streams (4,8), (3,8), (2,8), (1,8); snake_last on (1,8).
- From reset, 3 steps of dir=11 then 5 more steps of dir=11 → the step to y=0 sets failure and the head stays (3,1); further steps do nothing; stream is still valid.
- Grow to length 5 and steer down/left/up into the body → failure within 34 cycles of the offending step.
- Grow to 32 → success=1, state OVER, further steps are ignored.
- Assert rst mid-pass → snake_valid=0 on the next cycle, then re-INIT to (3,8) after 3 cycles.

Source files
------------

// File: rtl/snake_body_pkg.sv
// Shared playfield geometry, coordinate widths, directions and start-of-game constants for the snake block.
// Latency: none; this package holds only declarations.
// Backpressure: not applicable.
package snake_body_pkg;

    localparam int GAME_WIDTH  = 20;
    localparam int GAME_HEIGHT = 15;
    localparam int MAX_LEN     = 32;

    localparam int X_W   = 5;
    localparam int Y_W   = 4;
    localparam int LEN_W = 6;
    localparam int PTR_W = $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coord_t;

    // Head starts at (3,8); the body trails left to (1,8) in slots 1 and 0.
    localparam logic [X_W-1:0]   START_X   = X_W'(3);
    localparam logic [Y_W-1:0]   START_Y   = Y_W'(8);
    localparam logic [PTR_W-1:0] START_PTR = PTR_W'(2);
    localparam logic [LEN_W-1:0] START_LEN = LEN_W'(3);

    // Opposite directions differ only in bit 1 (right/left, down/up).
    function automatic logic is_opposite(input dir_e a, input dir_e b);
        return ((a ^ b) == 2'b10);
    endfunction

endpackage

// File: rtl/snake_body_streamer.sv
// Streams one segment per clock, head first, from a snapshot of (head_ptr, length) taken at each pass start.
// Latency: 1 cycle from index to registered snake_* outputs.
// Backpressure: none. Passes run back-to-back with no gap while en is high.
module snake_streamer
    import snake_body_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PTR_W-1:0] head_ptr,
    input  logic [LEN_W-1:0] length,
    output logic [PTR_W-1:0] rd_addr,
    input  coord_t           rd_dat,
    output logic             pass_start,
    output logic [X_W-1:0]   snake_x,
    output logic [Y_W-1:0]   snake_y,
    output logic             snake_first,
    output logic             snake_last,
    output logic             snake_valid
);

    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] snap_ptr;
    logic [LEN_W-1:0] snap_len;
    logic [PTR_W-1:0] cur_ptr;
    logic [LEN_W-1:0] cur_len;
    logic             at_last;

    // Index 0 reads the live pointer and length, which become the snapshot for the rest of the pass.
    always_comb begin
        cur_ptr    = (idx == '0) ? head_ptr : snap_ptr;
        cur_len    = (idx == '0) ? length   : snap_len;
        rd_addr    = cur_ptr - idx;
        at_last    = (LEN_W'(idx) == (cur_len - LEN_W'(1)));
        pass_start = en && (idx == '0);
    end

    // Advance the index, capture the snapshot, and register the segment with its flags.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            idx         <= '0;
            snap_ptr    <= '0;
            snap_len    <= '0;
            snake_x     <= '0;
            snake_y     <= '0;
            snake_first <= 1'b0;
            snake_last  <= 1'b0;
            snake_valid <= 1'b0;
        end else begin
            if (idx == '0) begin
                snap_ptr <= head_ptr;
                snap_len <= length;
            end
            idx         <= at_last ? '0 : (idx + PTR_W'(1));
            snake_x     <= rd_dat.x;
            snake_y     <= rd_dat.y;
            snake_first <= (idx == '0);
            snake_last  <= at_last;
            snake_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/snake_body.sv
// Snake segment buffer: applies step/grow moves, detects wall and self collisions, and feeds the segment streamer.
// Latency: head_x/head_y update 1 cycle after step; the stream trails the buffer by 1 cycle.
// Backpressure: none. A step outside RUN is dropped, and the stream never stalls.
module snake_body
    import snake_body_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [1:0]       dir,
    input  logic             grow,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [X_W-1:0]   snake_x,
    output logic [Y_W-1:0]   snake_y,
    output logic             snake_first,
    output logic             snake_last,
    output logic             snake_valid,
    output logic [LEN_W-1:0] length,
    output logic             failure,
    output logic             success
);

    state_e           state;
    state_e           state_nxt;
    logic [1:0]       init_cnt;
    logic [PTR_W-1:0] head_ptr;
    dir_e             last_dir;
    dir_e             dir_in;
    dir_e             eff_dir;
    coord_t           mem [MAX_LEN];

    logic [X_W:0]     nx;
    logic [Y_W:0]     ny;
    coord_t           new_head;
    logic             wall;
    logic             self_hit;
    logic [LEN_W-1:0] len_nxt;

    logic             move_ok;
    logic             set_fail;
    logic             set_succ;
    logic             mem_we;
    logic [PTR_W-1:0] mem_wa;
    coord_t           mem_wd;

    logic [PTR_W-1:0] rd_addr;
    coord_t           rd_dat;
    logic             pass_start;
    // Set when the head moves; cleared when a pass snapshots after the move.
    // While set, the streamed body may include a tail that has already been vacated, so it is not compared.
    logic             stale;

    assign dir_in = dir_e'(dir);
    assign rd_dat = mem[rd_addr];

    // Candidate head: one extra bit on each axis keeps GAME_WIDTH+1 and GAME_HEIGHT+1 representable for the wall test.
    always_comb begin
        eff_dir = is_opposite(dir_in, last_dir) ? last_dir : dir_in;
        nx      = {1'b0, head_x};
        ny      = {1'b0, head_y};
        case (eff_dir)
            DIR_RIGHT: nx = nx + (X_W+1)'(1);
            DIR_DOWN:  ny = ny + (Y_W+1)'(1);
            DIR_LEFT:  nx = nx - (X_W+1)'(1);
            DIR_UP:    ny = ny - (Y_W+1)'(1);
            default:   nx = nx;
        endcase
        new_head = {nx[X_W-1:0], ny[Y_W-1:0]};
        wall     = (nx == '0) || (nx == (X_W+1)'(GAME_WIDTH + 1)) ||
                   (ny == '0) || (ny == (Y_W+1)'(GAME_HEIGHT + 1));
        len_nxt  = length + LEN_W'(grow);
        self_hit = (state == ST_RUN) && snake_valid && !snake_first && !stale &&
                   (snake_x == head_x) && (snake_y == head_y);
    end

    // Next-state logic, plus the buffer write for initial fill and accepted moves.
    always_comb begin
        state_nxt = state;
        move_ok   = 1'b0;
        set_fail  = 1'b0;
        set_succ  = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = head_ptr + PTR_W'(1);
        mem_wd    = new_head;
        case (state)
            ST_INIT: begin
                mem_we = 1'b1;
                mem_wa = START_PTR - PTR_W'(init_cnt);
                mem_wd = {START_X - X_W'(init_cnt), START_Y};
                if (init_cnt == 2'd2) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (self_hit) begin
                    set_fail  = 1'b1;
                    state_nxt = ST_OVER;
                end else if (step) begin
                    if (wall) begin
                        // The buffer is left untouched so the displayed snake stays on the field.
                        set_fail  = 1'b1;
                        state_nxt = ST_OVER;
                    end else begin
                        move_ok = 1'b1;
                        mem_we  = 1'b1;
                        if (len_nxt == LEN_W'(MAX_LEN)) begin
                            set_succ  = 1'b1;
                            state_nxt = ST_OVER;
                        end
                    end
                end
            end
            ST_OVER: begin
                state_nxt = ST_OVER;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Segment buffer. Slots are only meaningful once written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Head, length, direction history, snapshot freshness and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
            head_ptr <= START_PTR;
            head_x   <= START_X;
            head_y   <= START_Y;
            length   <= START_LEN;
            last_dir <= DIR_RIGHT;
            failure  <= 1'b0;
            success  <= 1'b0;
            stale    <= 1'b1;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 2'd1;
            end
            if (move_ok) begin
                head_ptr <= head_ptr + PTR_W'(1);
                head_x   <= new_head.x;
                head_y   <= new_head.y;
                last_dir <= eff_dir;
                length   <= len_nxt;
                stale    <= 1'b1;
            end else if (pass_start) begin
                stale <= 1'b0;
            end
            if (set_fail) begin
                failure <= 1'b1;
            end
            if (set_succ) begin
                success <= 1'b1;
            end
        end
    end

    snake_streamer u_streamer (
        .clk         (clk),
        .rst         (rst),
        .en          (state != ST_INIT),
        .head_ptr    (head_ptr),
        .length      (length),
        .rd_addr     (rd_addr),
        .rd_dat      (rd_dat),
        .pass_start  (pass_start),
        .snake_x     (snake_x),
        .snake_y     (snake_y),
        .snake_first (snake_first),
        .snake_last  (snake_last),
        .snake_valid (snake_valid)
    );

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body with hand-computed expected heads, lengths, flags and streamed passes.
// Latency: inputs are driven on the falling edge, and outputs are sampled on the following falling edge.
// Backpressure: not applicable.
module tb_snake_body;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       grow = 1'b0;
    logic [4:0] head_x;
    logic [3:0] head_y;
    logic [4:0] snake_x;
    logic [3:0] snake_y;
    logic       snake_first;
    logic       snake_last;
    logic       snake_valid;
    logic [5:0] length;
    logic       failure;
    logic       success;

    int n_vec = 0;
    int n_err = 0;
    int px[40];
    int py[40];
    int ex[40];
    int ex_n;

    always #5 clk = ~clk;

    snake_body dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .dir         (dir),
        .grow        (grow),
        .head_x      (head_x),
        .head_y      (head_y),
        .snake_x     (snake_x),
        .snake_y     (snake_y),
        .snake_first (snake_first),
        .snake_last  (snake_last),
        .snake_valid (snake_valid),
        .length      (length),
        .failure     (failure),
        .success     (success)
    );

    function automatic int xy(input int x, input int y);
        return x * 16 + y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_run();
        @(negedge clk);
        rst  = 1'b1;
        step = 1'b0;
        grow = 1'b0;
        dir  = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_step(input logic [1:0] d, input logic g);
        @(negedge clk);
        dir  = d;
        grow = g;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        grow = 1'b0;
    endtask

    // Collect the next pass that starts after the current sample point.
    task automatic grab_pass(output int n);
        int t;
        n = 0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(snake_valid && snake_first) && t < 80);
        if (!(snake_valid && snake_first)) begin
            chk("pass_start", {31'd0, snake_valid & snake_first}, 1);
            return;
        end
        forever begin
            px[n] = snake_x;
            py[n] = snake_y;
            n++;
            if (snake_last || n >= 40) break;
            @(negedge clk);
        end
    endtask

    task automatic chk_pass(input string tag);
        int n;
        grab_pass(n);
        chk({tag, "_len"}, n, ex_n);
        for (int i = 0; i < ex_n; i++) begin
            chk($sformatf("%s_seg%0d", tag, i), xy(px[i], py[i]), ex[i]);
        end
    endtask

    task automatic set_row(input int hx, input int y, input int len);
        ex_n = len;
        for (int i = 0; i < len; i++) ex[i] = xy(hx - i, y);
    endtask

    initial begin
        int lat;

        // Reset state and INIT timing.
        repeat (2) @(negedge clk);
        chk("rst_head", xy(head_x, head_y), xy(3, 8));
        chk("rst_len", length, 3);
        chk("rst_valid", snake_valid, 0);
        chk("rst_fail", failure, 0);
        chk("rst_succ", success, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("init_valid_c1", snake_valid, 0);
        repeat (2) @(negedge clk);
        chk("init_valid_c3", snake_valid, 0);
        @(negedge clk);
        chk("first_valid", snake_valid, 1);
        chk("first_flag", snake_first, 1);
        chk("first_seg", xy(snake_x, snake_y), xy(3, 8));
        set_row(3, 8, 3);
        chk_pass("pass0");
        @(negedge clk);
        chk("no_gap", {31'd0, snake_valid & snake_first}, 1);
        chk("idle_len", length, 3);
        chk("idle_fail", failure, 0);

        // Two plain right moves.
        do_step(2'b00, 1'b0);
        chk("mv1_head", xy(head_x, head_y), xy(4, 8));
        do_step(2'b00, 1'b0);
        chk("mv2_head", xy(head_x, head_y), xy(5, 8));
        set_row(5, 8, 3);
        chk_pass("mv2");
        chk("mv2_len", length, 3);

        // Reverse request is ignored in favour of the current heading.
        reset_run();
        do_step(2'b10, 1'b0);
        chk("rev_head", xy(head_x, head_y), xy(4, 8));
        chk("rev_fail", failure, 0);

        // Growth, then chase the tail into its vacated cell.
        reset_run();
        do_step(2'b00, 1'b1);
        chk("grow_len", length, 4);
        set_row(4, 8, 4);
        chk_pass("grow");
        do_step(2'b01, 1'b0);
        do_step(2'b10, 1'b0);
        do_step(2'b11, 1'b0);
        chk("chase_head", xy(head_x, head_y), xy(3, 8));
        ex_n = 4;
        ex[0] = xy(3, 8); ex[1] = xy(3, 9); ex[2] = xy(4, 9); ex[3] = xy(4, 8);
        chk_pass("chase");
        repeat (40) @(negedge clk);
        chk("chase_fail", failure, 0);

        // Top wall.
        reset_run();
        for (int i = 0; i < 7; i++) do_step(2'b11, 1'b0);
        chk("wall_pre_head", xy(head_x, head_y), xy(3, 1));
        chk("wall_pre_fail", failure, 0);
        do_step(2'b11, 1'b0);
        chk("wall_fail", failure, 1);
        chk("wall_head", xy(head_x, head_y), xy(3, 1));
        do_step(2'b00, 1'b0);
        chk("wall_frozen", xy(head_x, head_y), xy(3, 1));
        ex_n = 3;
        ex[0] = xy(3, 1); ex[1] = xy(3, 2); ex[2] = xy(3, 3);
        chk_pass("wall");

        // Self collision at length 5.
        reset_run();
        do_step(2'b00, 1'b1);
        do_step(2'b00, 1'b1);
        do_step(2'b01, 1'b0);
        do_step(2'b10, 1'b0);
        chk("self_pre_fail", failure, 0);
        chk("self_len", length, 5);
        do_step(2'b11, 1'b0);
        chk("self_head", xy(head_x, head_y), xy(4, 8));
        lat = 0;
        while (!failure && lat < 34) begin
            @(negedge clk);
            lat++;
        end
        chk("self_hit", failure, 1);

        // Grow to MAX_LEN.
        reset_run();
        for (int i = 0; i < 17; i++) do_step(2'b00, 1'b1);
        for (int i = 0; i < 7; i++) do_step(2'b01, 1'b1);
        for (int i = 0; i < 4; i++) do_step(2'b10, 1'b1);
        chk("win_pre_len", length, 31);
        chk("win_pre_succ", success, 0);
        do_step(2'b10, 1'b1);
        chk("win_succ", success, 1);
        chk("win_len", length, 32);
        chk("win_fail", failure, 0);
        chk("win_head", xy(head_x, head_y), xy(15, 15));
        do_step(2'b01, 1'b1);
        chk("win_frozen_head", xy(head_x, head_y), xy(15, 15));
        chk("win_frozen_len", length, 32);

        // Reset in the middle of a pass.
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(snake_valid && !snake_first && !snake_last) && lat < 80);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", snake_valid, 0);
        chk("mid_rst_head", xy(head_x, head_y), xy(3, 8));
        chk("mid_rst_succ", success, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_init", snake_valid, 0);
        @(negedge clk);
        chk("mid_rst_first", {31'd0, snake_valid & snake_first}, 1);
        chk("mid_rst_seg", xy(snake_x, snake_y), xy(3, 8));
        chk("mid_rst_len", length, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
